// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared constants for the game logic running on the clk_ms domain:
//   - 2-bit game state encoding (ready / playing / over)
//   - playfield geometry (pipe slot size, land height, bird X, pipe spawn X)
//   - gap_y(): maps a random byte onto a legal gap-top Y coordinate
// -----------------------------------------------------------------------------
package game_pkg;

    // Game state as carried on the shared 2-bit bus; 3 behaves like ST_OVER.
    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    // Playfield geometry.
    localparam int SLOT_WIDTH  = 60;   // pipe width in pixels
    localparam int SLOT_HEIGHT = 100;  // vertical gap between upper and lower pipe
    localparam int LAND_HEIGHT = 80;   // ground strip height
    localparam int H_POS       = 320;  // bird X; a pipe counts as passed here
    localparam int SPAWN_X     = 740;  // right edge X of a freshly (re)entered pipe

    // Gap-top Y for a new pipe: y_min plus a random byte, 9-bit result.
    function automatic logic [8:0] gap_y(input logic [8:0] y_min, input logic [7:0] rnd);
        return y_min + {1'b0, rnd};
    endfunction

endpackage

// File: rtl/pipe_ctrl_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (shift right, new bit
// enters at bit 15). Advances every clock; only rst reloads the seed.
// Ports:
//   clk_ms  in   game clock
//   rst     in   asynchronous, active-high reset (loads SEED)
//   q       out  current LFSR value
// -----------------------------------------------------------------------------
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_ms,
    input  logic        rst,
    output logic [15:0] q
);

    logic feedback;

    // Tap positions 16,14,13,11 map to bits 0,2,3,5 in the right-shifting form.
    assign feedback = q[0] ^ q[2] ^ q[3] ^ q[5];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, matching the hardware regardless of block order.
    always_ff @(posedge clk_ms or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {feedback, q[15:1]};
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Scrolls two pipes (A and B) right-to-left, respawning them with random gap
// heights, picks the pipe the bird must clear next and counts passes.
// Ports:
//   clk_ms      in   1 kHz game clock
//   rst         in   asynchronous, active-high reset
//   state       in   game state: 0 ready, 1 playing, 2/3 over (freeze)
//   pip1_X/Y    out  right-edge X / gap-top Y of the collision target pipe
//   pip2_X/Y    out  X / Y of the other pipe (render only)
//   pip2_valid  out  other pipe has been launched
//   score       out  passed-pipe count, saturating at SCORE_MAX
//   pass_pulse  out  one-cycle pulse for each pass
// -----------------------------------------------------------------------------
module pipe_ctrl
    import game_pkg::*;
#(
    parameter int SPACING    = 370,
    parameter int SCROLL_DIV = 4,
    parameter int Y_MIN      = 220,
    parameter int INIT_Y     = 348,
    parameter int SCORE_MAX  = 999
) (
    input  logic       clk_ms,
    input  logic       rst,
    input  logic [1:0] state,
    output logic [9:0] pip1_X,
    output logic [8:0] pip1_Y,
    output logic [9:0] pip2_X,
    output logic [8:0] pip2_Y,
    output logic       pip2_valid,
    output logic [9:0] score,
    output logic       pass_pulse
);

    localparam int          DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [9:0]  SPAWN_L  = 10'(SPAWN_X);
    localparam logic [9:0]  LAUNCH_L = 10'(SPAWN_X - SPACING);
    localparam logic [9:0]  HPOS_L   = 10'(H_POS);
    localparam logic [9:0]  SMAX_L   = 10'(SCORE_MAX);
    localparam logic [8:0]  YMIN_L   = 9'(Y_MIN);
    localparam logic [8:0]  INITY_L  = 9'(INIT_Y);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

    logic [15:0]      lfsr;
    logic [9:0]       a_x, b_x, a_x_nxt, b_x_nxt;
    logic [8:0]       a_y, b_y, a_y_nxt, b_y_nxt;
    logic             b_active, sel, b_active_nxt, sel_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [9:0]       score_nxt;
    logic             pass_nxt;
    logic             step, b_launch;
    logic [8:0]       new_y;

    lfsr16 #(.SEED(16'hACE1)) u_lfsr (
        .clk_ms (clk_ms),
        .rst    (rst),
        .q      (lfsr)
    );

    assign step     = (div_cnt == DIV_LAST);
    assign b_launch = !b_active && (a_x == LAUNCH_L);
    assign new_y    = gap_y(YMIN_L, lfsr[7:0]);

    // NOTE: every variable gets its hold value first so no path through this
    // block leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        a_x_nxt      = a_x;
        a_y_nxt      = a_y;
        b_x_nxt      = b_x;
        b_y_nxt      = b_y;
        b_active_nxt = b_active;
        sel_nxt      = sel;
        div_cnt_nxt  = div_cnt;
        score_nxt    = score;
        pass_nxt     = 1'b0;

        if (state == ST_READY) begin
            // Hold the reset layout so leaving ready always starts clean.
            a_x_nxt      = SPAWN_L;
            b_x_nxt      = SPAWN_L;
            a_y_nxt      = INITY_L;
            b_y_nxt      = INITY_L;
            b_active_nxt = 1'b0;
            sel_nxt      = 1'b0;
            div_cnt_nxt  = '0;
            score_nxt    = '0;
        end else if (state == ST_PLAY) begin
            div_cnt_nxt = step ? '0 : div_cnt + 1'b1;
            if (step) begin
                // X == 0 reloads, so the decrement never underflows.
                if (a_x == '0) begin
                    a_x_nxt = SPAWN_L;
                    a_y_nxt = new_y;
                end else begin
                    a_x_nxt = a_x - 1'b1;
                end

                if (b_active || b_launch) begin
                    if (b_x == '0) begin
                        b_x_nxt = SPAWN_L;
                        b_y_nxt = new_y;
                    end else begin
                        b_x_nxt = b_x - 1'b1;
                    end
                end
                if (b_launch) begin
                    b_active_nxt = 1'b1;
                    b_y_nxt      = new_y;
                end

                // Pass is judged on the target's post-step X.
                if ((sel ? b_x_nxt : a_x_nxt) == HPOS_L) begin
                    sel_nxt   = !sel;
                    pass_nxt  = 1'b1;
                    score_nxt = (score >= SMAX_L) ? SMAX_L : score + 1'b1;
                end
            end
        end
        // States 2/3 freeze: defaults hold everything, pass_nxt stays low.
    end

    always_ff @(posedge clk_ms or posedge rst) begin
        if (rst) begin
            a_x        <= SPAWN_L;
            b_x        <= SPAWN_L;
            a_y        <= INITY_L;
            b_y        <= INITY_L;
            b_active   <= 1'b0;
            sel        <= 1'b0;
            div_cnt    <= '0;
            score      <= '0;
            pass_pulse <= 1'b0;
        end else begin
            a_x        <= a_x_nxt;
            b_x        <= b_x_nxt;
            a_y        <= a_y_nxt;
            b_y        <= b_y_nxt;
            b_active   <= b_active_nxt;
            sel        <= sel_nxt;
            div_cnt    <= div_cnt_nxt;
            score      <= score_nxt;
            pass_pulse <= pass_nxt;
        end
    end

    assign pip1_X     = sel ? b_x : a_x;
    assign pip1_Y     = sel ? b_y : a_y;
    assign pip2_X     = sel ? a_x : b_x;
    assign pip2_Y     = sel ? a_y : b_y;
    assign pip2_valid = b_active | sel;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl with a cycle-level reference model. Each pass
// the model predicts is queued and compared when the DUT pulses pass_pulse.
// SCORE_MAX is lowered so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int SMAX  = 3;
    localparam int SPAWN = 740;
    localparam int LAUNCH_AT = 370;
    localparam int HPOS  = 320;
    localparam int DIV   = 4;
    localparam int YMIN  = 220;
    localparam int INITY = 348;

    typedef struct {
        int score;
        int p1x;
        int p2x;
    } pass_t;

    logic       clk_ms = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic [9:0] pip1_X, pip2_X, score;
    logic [8:0] pip1_Y, pip2_Y;
    logic       pip2_valid, pass_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int play_cyc = 0;
    int n_pulse  = 0;
    int guard;

    // Reference model state
    logic [15:0] m_lfsr;
    int m_ax, m_ay, m_bx, m_by, m_div, m_score;
    bit m_bact, m_sel;
    pass_t sb[$];

    pipe_ctrl #(.SCORE_MAX(SMAX)) dut (
        .clk_ms     (clk_ms),
        .rst        (rst),
        .state      (state),
        .pip1_X     (pip1_X),
        .pip1_Y     (pip1_Y),
        .pip2_X     (pip2_X),
        .pip2_Y     (pip2_Y),
        .pip2_valid (pip2_valid),
        .score      (score),
        .pass_pulse (pass_pulse)
    );

    always #5 clk_ms = ~clk_ms;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] b;
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
        return (v >> 1) | (b << 15);
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_ax = SPAWN; m_bx = SPAWN; m_ay = INITY; m_by = INITY;
        m_bact = 0; m_sel = 0; m_div = 0; m_score = 0;
        sb.delete();
    endtask

    task automatic model_step(input logic [1:0] st);
        int na, nb, ny;
        bit launch;
        pass_t e;
        ny = YMIN + int'(m_lfsr & 16'h00FF);
        if (st == 2'd0) begin
            m_ax = SPAWN; m_bx = SPAWN; m_ay = INITY; m_by = INITY;
            m_bact = 0; m_sel = 0; m_div = 0; m_score = 0;
        end else if (st == 2'd1) begin
            if (m_div == DIV - 1) begin
                m_div = 0;
                na = (m_ax == 0) ? SPAWN : m_ax - 1;
                if (m_ax == 0) m_ay = ny;
                launch = !m_bact && (m_ax == LAUNCH_AT);
                nb = m_bx;
                if (m_bact || launch) begin
                    nb = (m_bx == 0) ? SPAWN : m_bx - 1;
                    if (m_bx == 0) m_by = ny;
                end
                if (launch) begin
                    m_bact = 1;
                    m_by = ny;
                end
                m_ax = na;
                m_bx = nb;
                if ((m_sel ? nb : na) == HPOS) begin
                    m_sel = !m_sel;
                    m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
                    e.score = m_score;
                    e.p1x = m_sel ? m_bx : m_ax;
                    e.p2x = m_sel ? m_ax : m_bx;
                    sb.push_back(e);
                end
            end else begin
                m_div = m_div + 1;
            end
        end
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    // One clock: advance the model, let the edge happen, sample 1 time unit later.
    task automatic tick();
        pass_t e;
        if (rst) model_reset();
        else model_step(state);
        @(posedge clk_ms);
        #1;
        if (!rst && state == 2'd1) play_cyc++;
        if (pass_pulse === 1'b1) begin
            n_pulse++;
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_score", 32'(score), 32'(e.score));
                check("sb_pip1_X", 32'(pip1_X), 32'(e.p1x));
                check("sb_pip2_X", 32'(pip2_X), 32'(e.p2x));
            end
        end
    endtask

    task automatic run_play(input int target);
        guard = 0;
        while (play_cyc < target && guard < 20000) begin
            tick();
            guard++;
        end
        check("run_play_reached", 32'(play_cyc), 32'(target));
    endtask

    initial begin
        rst = 1'b1;
        state = 2'd0;
        model_reset();
        #2;
        check("rst_pip1_X", 32'(pip1_X), 32'(SPAWN));
        check("rst_pip1_Y", 32'(pip1_Y), 32'(INITY));
        check("rst_pip2_valid", 32'(pip2_valid), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_pass_pulse", 32'(pass_pulse), 32'd0);
        tick();
        rst = 1'b0;

        // Scroll rate: first step lands on the 4th playing cycle.
        state = 2'd1;
        run_play(3);
        check("scroll_c3", 32'(pip1_X), 32'd740);
        run_play(4);
        check("scroll_c4", 32'(pip1_X), 32'd739);
        run_play(40);
        check("scroll_c40", 32'(pip1_X), 32'd730);

        // Freeze: positions hold, no pulses; the LFSR keeps running.
        state = 2'd2;
        repeat (100) tick();
        check("freeze_pip1_X", 32'(pip1_X), 32'd730);
        check("freeze_pass_pulse", 32'(pass_pulse), 32'd0);

        // B launch on the step where A leaves X=370.
        state = 2'd1;
        run_play(1483);
        check("pre_launch_valid", 32'(pip2_valid), 32'd0);
        run_play(1484);
        check("launch_valid", 32'(pip2_valid), 32'd1);
        check("launch_pip1_X", 32'(pip1_X), 32'd369);
        check("launch_pip2_X", 32'(pip2_X), 32'd739);
        check("launch_pip1_Y", 32'(pip1_Y), 32'(INITY));
        check("launch_pip2_Y", 32'(pip2_Y), 32'(m_by));

        // First pass: A reaches H_POS, target switches to B.
        run_play(1680);
        check("pass1_pulse", 32'(pass_pulse), 32'd1);
        check("pass1_score", 32'(score), 32'd1);
        check("pass1_pip1_X", 32'(pip1_X), 32'd690);
        check("pass1_pip2_X", 32'(pip2_X), 32'd320);
        run_play(1681);
        check("pass1_pulse_drop", 32'(pass_pulse), 32'd0);

        // Respawn of A (now the non-target pipe).
        run_play(2960);
        check("respawn_at_zero", 32'(pip2_X), 32'd0);
        run_play(2964);
        check("respawn_pip2_X", 32'(pip2_X), 32'(SPAWN));
        check("respawn_pip2_Y", 32'(pip2_Y), 32'(m_ay));
        check("respawn_y_range", 32'(pip2_Y >= 9'd220 && pip2_Y <= 9'd475), 32'd1);

        // Saturation: the 4th pass must leave the score at SMAX.
        guard = 0;
        while (n_pulse < 4 && guard < 8000) begin
            tick();
            guard++;
        end
        check("pulses_seen", 32'(n_pulse), 32'd4);
        check("sat_score", 32'(score), 32'(SMAX));
        repeat (3) tick();
        check("sat_score_hold", 32'(score), 32'(SMAX));
        check("sat_pulse_drop", 32'(pass_pulse), 32'd0);

        // Return to ready restores the reset layout within one cycle.
        state = 2'd0;
        tick();
        check("ready_pip1_X", 32'(pip1_X), 32'(SPAWN));
        check("ready_pip1_Y", 32'(pip1_Y), 32'(INITY));
        check("ready_pip2_X", 32'(pip2_X), 32'(SPAWN));
        check("ready_pip2_Y", 32'(pip2_Y), 32'(INITY));
        check("ready_pip2_valid", 32'(pip2_valid), 32'd0);
        check("ready_score", 32'(score), 32'd0);

        // Play to the next pass, then reset asynchronously while the pulse is high.
        state = 2'd1;
        guard = 0;
        while (n_pulse < 5 && guard < 2000) begin
            tick();
            guard++;
        end
        check("replay_pulse", 32'(pass_pulse), 32'd1);
        check("replay_score", 32'(score), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_pass_pulse", 32'(pass_pulse), 32'd0);
        check("async_pip1_X", 32'(pip1_X), 32'(SPAWN));
        check("async_pip1_Y", 32'(pip1_Y), 32'(INITY));
        check("async_pip2_valid", 32'(pip2_valid), 32'd0);
        check("async_score", 32'(score), 32'd0);
        tick();
        rst = 1'b0;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
